alu_muldiv: RTL and testbench

- Parametrised iterative multiply/divide unit alongside the single-cycle ALU in the CPU execute stage.
- Implements the eight RV32M operations at a configurable width using a start/busy/done handshake.
- Stalls the pipeline while busy; one operation in flight at a time.

---
 rtl/alu_muldiv.sv | 200 ++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide unit for the execute stage.
// Sequence: IDLE -> PREP (take operand magnitudes, record result sign) ->
// CALC (WIDTH cycles, one product/quotient bit each) -> FIN (sign-corrected
// result with a one-cycle done pulse) -> IDLE. One operation in flight.
// Optional macro ALU_MULDIV_EARLY_OUT_EN: a multiply with a zero operand or a
// divide by zero skips CALC and goes straight from PREP to FIN.
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           request, accepted only in IDLE and not alongside flush
//   op[2:0]         0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   dataa, datab    rs1 / rs2, captured when start is accepted
//   flush           abandons the in-flight operation without a done pulse
//   busy            high from the cycle after acceptance through FIN
//   done            one-cycle pulse in FIN; result valid that cycle
//   result          registered result, changes only in FIN or at reset
module alu_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned DW    = 2 * WIDTH;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIN} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [DW-1:0]    acc_q, acc_d;     // {high/remainder, low/multiplier/quotient}
  logic             neg_q, neg_d;     // negate the final value in FIN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  // Operand interpretation of the latched operation
  logic             is_mul_c, a_signed_c, b_signed_c, a_neg_c, b_neg_c, b_zero_c;
  logic [WIDTH-1:0] a_abs_c, b_abs_c;

  assign is_mul_c   = ~op_q[2];
  assign a_signed_c = (op_q == OP_MULH) || (op_q == OP_MULHSU) ||
                      (op_q == OP_DIV)  || (op_q == OP_REM);
  assign b_signed_c = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
  assign a_neg_c    = a_signed_c & a_q[WIDTH-1];
  assign b_neg_c    = b_signed_c & b_q[WIDTH-1];
  assign b_zero_c   = (b_q == '0);
  assign a_abs_c    = a_neg_c ? (~a_q + WIDTH'(1)) : a_q;
  assign b_abs_c    = b_neg_c ? (~b_q + WIDTH'(1)) : b_q;

  // One shift-add multiply step: add multiplicand on multiplier LSB, shift right
  logic [WIDTH:0]   mul_sum_c;
  logic [DW-1:0]    mul_next_c;
  assign mul_sum_c  = {1'b0, acc_q[DW-1:WIDTH]} + {1'b0, opnd_q};
  assign mul_next_c = acc_q[0] ? {mul_sum_c, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[DW-1:1]};

  // One restoring divide step; a zero divisor yields all-ones quotient and
  // leaves the dividend in the remainder, which matches RV32M
  logic [WIDTH:0]   div_shift_c;
  logic [WIDTH-1:0] div_diff_c;
  logic             div_ge_c;
  logic [DW-1:0]    div_next_c;
  assign div_shift_c = acc_q[DW-1:WIDTH-1];
  assign div_ge_c    = div_shift_c >= {1'b0, opnd_q};
  assign div_diff_c  = div_shift_c[WIDTH-1:0] - opnd_q;
  assign div_next_c  = div_ge_c ? {div_diff_c, acc_q[WIDTH-2:0], 1'b1}
                                : {acc_q[DW-2:0], 1'b0};

  logic [DW-1:0]    step_c;
  assign step_c = is_mul_c ? mul_next_c : div_next_c;

  // Sign correction of the value produced by the last CALC step
  logic [DW-1:0]    prod_c;
  logic [WIDTH-1:0] quo_c, rem_c, fin_c;
  assign prod_c = neg_q ? (~step_c + DW'(1)) : step_c;
  assign quo_c  = neg_q ? (~step_c[WIDTH-1:0] + WIDTH'(1)) : step_c[WIDTH-1:0];
  assign rem_c  = neg_q ? (~step_c[DW-1:WIDTH] + WIDTH'(1)) : step_c[DW-1:WIDTH];
  assign fin_c  = is_mul_c ? ((op_q == OP_MUL) ? prod_c[WIDTH-1:0] : prod_c[DW-1:WIDTH])
                           : (op_q[1] ? rem_c : quo_c);

`ifdef ALU_MULDIV_EARLY_OUT_EN
  // Trivial operands whose result is known without iterating
  logic             early_hit_c;
  logic [WIDTH-1:0] early_res_c;
  assign early_hit_c = is_mul_c ? ((a_q == '0) || b_zero_c) : b_zero_c;
  assign early_res_c = is_mul_c ? '0 : (op_q[1] ? a_q : '1);
`endif

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d = S_PREP;
          op_d    = op;
          a_d     = dataa;
          b_d     = datab;
        end
      end
      S_PREP: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_CALC;
          acc_d   = {{WIDTH{1'b0}}, a_abs_c};
          opnd_d  = b_abs_c;
          cnt_d   = '0;
          if (is_mul_c)     neg_d = a_neg_c ^ b_neg_c;
          else if (op_q[1]) neg_d = a_neg_c;
          else              neg_d = (a_neg_c ^ b_neg_c) & ~b_zero_c;
`ifdef ALU_MULDIV_EARLY_OUT_EN
          if (early_hit_c) begin
            state_d  = S_FIN;
            result_d = early_res_c;
          end
`endif
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = S_FIN;
            result_d = fin_c;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: runs a 32-bit and an 8-bit alu_muldiv side by side from the
// same stimulus and compares both against an arithmetic RV32M reference.
// Honours ALU_MULDIV_EARLY_OUT_EN for the expected latency.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  op;
  logic [31:0] dataa, datab;
  logic        busy32, done32, busy8, done8;
  logic [31:0] res32;
  logic [7:0]  res8;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] prev32, r32;
  logic [7:0]  prev8, r8;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .dataa(dataa), .datab(datab),
    .flush(flush), .busy(busy32), .done(done32), .result(res32)
  );

  alu_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .dataa(dataa[7:0]), .datab(datab[7:0]),
    .flush(flush), .busy(busy8), .done(done8), .result(res8)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input logic [63:0] v, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return v[w-1] ? longint'(v | ~m) : longint'(v & m);
  endfunction

  // RV32M semantics at width w, computed with 64-bit integer arithmetic
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [63:0] a,
                                            input logic [63:0] b, input int w);
    logic [63:0]      m, ua, ub;
    longint           sa, sb, p;
    longint unsigned  up;
    m  = (64'd1 << w) - 64'd1;
    ua = a & m;
    ub = b & m;
    sa = sx(a, w);
    sb = sx(b, w);
    case (o)
      3'd0: begin p = sa * sb; return 64'(p) & m; end
      3'd1: begin p = sa * sb; return 64'(p >>> w) & m; end
      3'd2: begin p = sa * longint'(ub); return 64'(p >>> w) & m; end
      3'd3: begin up = ua * ub; return 64'(up >> w) & m; end
      3'd4: begin if (sb == 0) return m; p = sa / sb; return 64'(p) & m; end
      3'd5: begin if (ub == 0) return m; return (ua / ub) & m; end
      3'd6: begin if (sb == 0) return ua; p = sa % sb; return 64'(p) & m; end
      default: begin if (ub == 0) return ua; return (ua % ub) & m; end
    endcase
  endfunction

  // Cycle (counted from the acceptance edge) in which done is expected
  function automatic int exp_lat(input logic [2:0] o, input logic [63:0] a,
                                 input logic [63:0] b, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
`ifdef ALU_MULDIV_EARLY_OUT_EN
    if (o[2] && ((b & m) == 0)) return 2;
    if (!o[2] && (((a & m) == 0) || ((b & m) == 0))) return 2;
`else
    if (o == 3'd7 && a == 64'd0 && m == 64'd0) return 0;
`endif
    return w + 2;
  endfunction

  // Issue one operation to both units, watch handshake, check results
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int flush_cyc,
                        output logic [31:0] r32o, output logic [7:0] r8o);
    logic [31:0] e32;
    logic [7:0]  e8;
    int lat32 = 0, lat8 = 0, hs32 = 0, hs8 = 0, el32, el8, last;
    e32  = 32'(ref_model(o, 64'(a), 64'(b), 32));
    e8   = 8'(ref_model(o, 64'(a[7:0]), 64'(b[7:0]), 8));
    el32 = exp_lat(o, 64'(a), 64'(b), 32);
    el8  = exp_lat(o, 64'(a[7:0]), 64'(b[7:0]), 8);
    r32o = 'x;
    r8o  = 'x;
    @(negedge clk);
    start = 1'b1; op = o; dataa = a; datab = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'($urandom); dataa = $urandom; datab = $urandom;
    last = (flush_cyc > 0) ? flush_cyc + 1 : 40;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      flush = (k == flush_cyc);
      if (flush_cyc > 0 && k > flush_cyc) begin
        if (busy32 !== 1'b0 || done32 !== 1'b0) hs32++;
      end else if (lat32 == 0) begin
        if (busy32 !== 1'b1) hs32++;
        if (done32 === 1'b1) begin lat32 = k; r32o = res32; end
      end else if (busy32 !== 1'b0 || done32 !== 1'b0 || res32 !== r32o) begin
        hs32++;
      end
      if (lat8 == 0) begin
        if (busy8 !== 1'b1) hs8++;
        if (done8 === 1'b1) begin lat8 = k; r8o = res8; end
      end else if (busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== r8o) begin
        hs8++;
      end
    end
    flush = 1'b0;
    if (flush_cyc > 0) begin
      chk({tag, "_nodone32"}, 64'(lat32), 64'd0);
      chk({tag, "_hold32"}, 64'(res32), 64'(prev32));
    end else begin
      chk({tag, "_lat32"}, 64'(lat32), 64'(el32));
      chk({tag, "_res32"}, 64'(r32o), 64'(e32));
      prev32 = e32;
    end
    chk({tag, "_hs32"}, 64'(hs32), 64'd0);
    chk({tag, "_lat8"}, 64'(lat8), 64'(el8));
    chk({tag, "_res8"}, 64'(r8o), 64'(e8));
    chk({tag, "_hs8"}, 64'(hs8), 64'd0);
    prev8 = e8;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0080;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dn;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; dataa = '0; datab = '0;
    prev32 = '0; prev8 = '0;
    #12;
    chk("rst_busy32", 64'(busy32), 64'd0);
    chk("rst_done32", 64'(done32), 64'd0);
    chk("rst_res32", 64'(res32), 64'd0);
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_res8", 64'(res8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul", 3'd0, 32'h0000_1234, 32'h0000_5678, 0, r32, r8);
    chk("mul_spec", 64'(r32), 64'h0626_0060);

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    start = 1'b1; op = 3'd5; dataa = 32'd12345; datab = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy32", 64'(busy32), 64'd0);
    chk("arst_done32", 64'(done32), 64'd0);
    chk("arst_res32", 64'(res32), 64'd0);
    chk("arst_res8", 64'(res8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev32 = '0; prev8 = '0;
    dn = 0;
    repeat (40) begin @(negedge clk); if (done32 === 1'b1 || busy32 === 1'b1) dn++; end
    chk("arst_quiet", 64'(dn), 64'd0);

    run_op("mulh", 3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 0, r32, r8);
    chk("mulh_spec", 64'(r32), 64'hFFFF_FFFF);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFE, 32'h0000_0003, 0, r32, r8);
    chk("mulhu_spec", 64'(r32), 64'h0000_0002);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r32, r8);
    chk("mulhsu_spec", 64'(r32), 64'hFFFF_FFFF);
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 0, r32, r8);
    chk("div_spec", 64'(r32), 64'hFFFF_FFFD);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 0, r32, r8);
    chk("rem_spec", 64'(r32), 64'hFFFF_FFFF);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, r32, r8);
    chk("divovf_spec", 64'(r32), 64'h8000_0000);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, r32, r8);
    chk("removf_spec", 64'(r32), 64'h0);
    run_op("divu0", 3'd5, 32'h0000_0005, 32'h0000_0000, 0, r32, r8);
    chk("divu0_spec", 64'(r32), 64'hFFFF_FFFF);
    run_op("remu0", 3'd7, 32'h0000_0005, 32'h0000_0000, 0, r32, r8);
    chk("remu0_spec", 64'(r32), 64'h5);
    run_op("div0", 3'd4, 32'hFFFF_FFF9, 32'h0000_0000, 0, r32, r8);
    run_op("rem0", 3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 0, r32, r8);

    // Flush in CALC, then an immediate restart
    run_op("flush", 3'd5, 32'd100000, 32'd7, 10, r32, r8);
    run_op("after_flush", 3'd5, 32'd100000, 32'd7, 0, r32, r8);
    chk("after_flush_spec", 64'(r32), 64'd14285);

    // start together with flush in IDLE is ignored
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd0; dataa = 32'd3; datab = 32'd4;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("idle_flush_busy32", 64'(busy32), 64'd0);
    chk("idle_flush_busy8", 64'(busy8), 64'd0);

    run_op("mul8", 3'd0, 32'h0000_0012, 32'h0000_0034, 0, r32, r8);
    chk("mul8_spec", 64'(r8), 64'hA8);

    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rnd%0d", i), 3'($urandom), pick(), pick(), 0, r32, r8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
